// File: rtl/sqrt_arb_pkg.sv
// sqrt_arb_pkg: shared FSM states, float constants and operand width for sqrt_rom_arbiter
package sqrt_arb_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_e;
  localparam logic [31:0] FP_ZERO  = 32'h00000000;
  localparam logic [31:0] FP_ONE   = 32'h3F800000;
  localparam logic [31:0] FP_TWO   = 32'h40000000;
  localparam logic [31:0] FP_THREE = 32'h40400000;
  localparam int N_W = 4;
endpackage

// File: rtl/sqrt_rr_pick.sv
// sqrt_rr_pick: combinational round-robin select, first set request at or after ptr with wrap
module sqrt_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  logic [IDW-1:0] j;
  // scan offsets from farthest to nearest so the nearest set bit from ptr wins
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = IDW'((int'(ptr_i) + k) % NREQ);
      if (req_i[j]) begin
        idx_o = j;
        any_o = 1'b1;
      end
    end
  end
  assign gnt_o = any_o ? NREQ'(1) << idx_o : '0;
endmodule

// File: rtl/sqrt_rom_arbiter.sv
// sqrt_rom_arbiter: round-robin sharing of one sqrt ROM among NREQ requesters; SQRT_ARB_BYPASS_EN adds a one-entry result cache
module sqrt_rom_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [N_W*NREQ-1:0] req_n,
  output logic [NREQ-1:0]     req_ready,
  output logic [N_W-1:0]      rom_n,
  input  logic [31:0]         rom_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [31:0]         resp_data,
  output logic [IDW-1:0]      resp_id
);
  state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, id_q, id_d, g_idx;
  logic [N_W-1:0] n_q, n_d, g_n;
  logic [31:0] data_q, data_d;
  logic [NREQ-1:0] g_onehot;
  logic g_any, idle, accept;
`ifdef SQRT_ARB_BYPASS_EN
  logic c_vld_q, c_vld_d;
  logic [N_W-1:0] c_n_q, c_n_d;
  logic [31:0] c_data_q, c_data_d;
`endif

  sqrt_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (g_onehot),
    .idx_o (g_idx),
    .any_o (g_any)
  );

  assign idle       = state_q == IDLE;
  assign req_ready  = (idle && rst_n && g_any) ? g_onehot : '0;
  assign accept     = |(req_ready & req_valid);
  assign rom_n      = n_q;
  assign resp_valid = state_q == RESP;
  assign resp_data  = data_q;
  assign resp_id    = id_q;

  // operand mux for the granted requester
  always_comb begin
    g_n = '0;
    for (int i = 0; i < NREQ; i++) if (g_onehot[i]) g_n = req_n[i*N_W +: N_W];
  end

  // next-state and datapath updates: accept in IDLE, capture ROM in LOOKUP, handshake in RESP
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    n_d = n_q;
    data_d = data_q;
`ifdef SQRT_ARB_BYPASS_EN
    c_vld_d = c_vld_q;
    c_n_d = c_n_q;
    c_data_d = c_data_q;
`endif
    if (idle && accept) begin
      ptr_d = IDW'((int'(g_idx) + 1) % NREQ);
      id_d = g_idx;
      n_d = g_n;
      state_d = LOOKUP;
`ifdef SQRT_ARB_BYPASS_EN
      if (c_vld_q && c_n_q == g_n) begin
        state_d = RESP;
        data_d = c_data_q;
      end
`endif
    end else if (state_q == LOOKUP) begin
      state_d = RESP;
      data_d = rom_data;
`ifdef SQRT_ARB_BYPASS_EN
      c_vld_d = 1'b1;
      c_n_d = n_q;
      c_data_d = rom_data;
`endif
    end else if (state_q == RESP && resp_ready) begin
      state_d = IDLE;
    end
  end

  // state and datapath registers, cleared by synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      n_q <= '0;
      data_q <= FP_ZERO;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      n_q <= n_d;
      data_q <= data_d;
    end
  end

`ifdef SQRT_ARB_BYPASS_EN
  // one-entry cache of the last ROM lookup; valid bit clears on reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_vld_q <= 1'b0;
      c_n_q <= '0;
      c_data_q <= FP_ZERO;
    end else begin
      c_vld_q <= c_vld_d;
      c_n_q <= c_n_d;
      c_data_q <= c_data_d;
    end
  end
`endif
endmodule

// File: doc/sqrt_rom_arbiter.md
# sqrt_rom_arbiter

Round-robin arbiter and sequencer that shares one combinational square-root ROM among `NREQ` requesters. Each requester presents a 4-bit operand `n`. The block grants one requester, drives the ROM address, and captures the 32-bit IEEE-754 single-precision result. It returns the result on a shared response channel tagged with the requester index. It sits between the client blocks and the single ROM instance.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, `$clog2(NREQ)`: width of the requester index.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_n`  in  4*NREQ  packed operands; requester i uses bits `[4i+3:4i]`.
- `req_ready`  out  NREQ  one-hot grant/accept; at most one bit is high.
- `rom_n`  out  4  ROM address.
- `rom_data`  in  32  ROM output: float bits of sqrt(n+1) for n=0..14, and 0.0 for n=15.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_data`  out  32  registered result.
- `resp_id`  out  IDW  index of the requester that owns `resp_data`.

## Operation
- FSM states:
  - IDLE: pick a requester; on accept, latch `n` and the requester index, then go to LOOKUP.
  - LOOKUP: `rom_n` = latched `n`; capture `rom_data` into `resp_data` at the clock edge; go to RESP.
  - RESP: hold `resp_valid`; on `resp_valid & resp_ready`, go to IDLE.
- Arbitration:
  - Round-robin over the `req_valid` bits, searching from pointer `ptr` upward with wrap from NREQ-1 to 0.
  - Grant is combinational in IDLE only: `req_ready[g]=1` for the winner g, all other bits 0. Outside IDLE, `req_ready` = 0.
  - A request is accepted when `req_valid[g] & req_ready[g]`. On accept, `ptr <= (g+1) mod NREQ`.
- Requesters hold `req_valid` and `req_n` stable until accepted. The block never drops a pending request.
- `rom_n` is driven with the latched operand in every state. It changes only on accept, so the ROM input is glitch-free during LOOKUP.
- `resp_data` and `resp_id` are stable while `resp_valid` is high and `resp_ready` is low.
- The 4-bit operand is passed through unmodified. The block does not adjust for the n+1 offset; that is the ROM's function.

## Timing
- Reset values:
  - state = IDLE, `ptr` = 0.
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0.
  - `rom_n` = 0, `req_ready` = 0 during reset.
- Latency: accept in cycle T, LOOKUP in T+1, `resp_valid` high in T+2.
- Throughput: with `resp_ready` tied high, one result every 3 cycles. Throughput is 1/3 per cycle, shared across all requesters.
- After the response handshake in cycle R, the next accept is possible in cycle R+1. There is no overlap between a response handshake and an accept.
- Simultaneous requests: the winner is the first set bit at or after `ptr`. Losers wait in IDLE for their turn.
- A `req_valid` bit that drops in IDLE before grant is simply not selected; this is legal only before acceptance.
- Reset asserted mid-operation (LOOKUP or RESP): the in-flight result is discarded and there is no response; all state returns to reset values on that edge.
- With `resp_ready` held low, the block stalls indefinitely in RESP and `req_ready` stays 0.

## Configuration
- `SQRT_ARB_BYPASS_EN`:
  - Defined: the block keeps a one-entry cache of the last looked-up `n`, its result, and a valid bit. On accept, if the cache is valid and the operand matches, the FSM goes IDLE→RESP directly with the cached data, giving latency 1 cycle. Accept in T, `resp_valid` in T+1. The cache valid bit clears on reset.
  - Undefined: every request goes through LOOKUP; no cache registers exist.

## Structure
- `sqrt_arb_pkg` contains:
  - the state enum (IDLE, LOOKUP, RESP);
  - float constants `FP_ZERO=32'h00000000`, `FP_ONE=32'h3F800000`, `FP_TWO=32'h40000000`, `FP_THREE=32'h40400000`;
  - the operand width constant `N_W=4`.
- One sub-module, `sqrt_rr_pick`: combinational round-robin select. Inputs are the request vector and `ptr`; outputs are the one-hot grant, the index, and `any`.
- The ROM is instantiated outside this block and connected through `rom_n` and `rom_data`.

## Test plan
- Reset, then a single request on req 0 with n=3: `req_ready[0]` high in T, `resp_valid` in T+2 with `resp_data=32'h40000000`, `resp_id=0`.
- All 4 requesters valid, with n = 0, 8, 15, 3: grants in order 0,1,2,3. Responses are `3F800000`, `40400000`, `00000000`, `40000000`. `ptr` ends at 0.
- `resp_ready` held low 5 cycles in RESP: `resp_data` and `resp_id` stay stable, `req_ready` stays 0, and the next grant comes only after the handshake.
- Reset asserted in LOOKUP with n=8 in flight: no `resp_valid`, all outputs return to 0, and a fresh request on req 2 is granted first.
- With `SQRT_ARB_BYPASS_EN` defined, two back-to-back requests with n=8: the second has `resp_valid` at T+1 with `40400000`. With the macro undefined, it arrives at T+2.
- Requester 1 streams continuously while requester 3 is pending: grants alternate 1,3,1,3, so no starvation.
